// File: rtl/snn_pkg.sv
// Shared defaults and scheduler state encoding for the spiking-network datapath.
package snn_pkg;
  localparam int N_IN_DEF   = 8;
  localparam int IDX_W_DEF  = 3;
  localparam int DROP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } sched_state_e;
endpackage

// File: rtl/spike_event_scheduler_if.sv
// Event channel from the spike scheduler to the downstream accumulator.
interface spike_event_scheduler_if import snn_pkg::*; #(
  parameter int IDX_W = IDX_W_DEF
);
  // Transfer happens on a rising clk where evt_valid & evt_ready; once evt_valid
  // rises, evt_valid and evt_idx hold unchanged until that transfer cycle.
  logic             evt_valid;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_ready;

  modport master (output evt_valid, output evt_idx, input evt_ready);
  modport slave  (input evt_valid, input evt_idx, output evt_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping modulo N_IN.
module rr_arbiter import snn_pkg::*; #(
  parameter int N_IN  = N_IN_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);
  logic [N_IN-1:0] req_rot;

  // Rotating a doubled copy puts the bit at ptr in position 0.
  assign req_rot = N_IN'({req, req} >> ptr);

  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any    = 1'b1;
        winner = IDX_W'((int'(ptr) + k) % N_IN);
      end
    end
  end
endmodule

// File: rtl/spike_event_scheduler.sv
// Captures input spikes into a pending set and offers them one at a time, round-robin.
module spike_event_scheduler import snn_pkg::*; #(
  parameter int N_IN   = N_IN_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot_mode,
  input  logic [N_IN-1:0]      edge_spike,
  input  logic                 drop_clr,
  spike_event_scheduler_if.master evt,
  output logic [N_IN-1:0]      pending,
  output logic                 busy,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt,
  output sched_state_e         state_dbg,
  output logic [IDX_W-1:0]     rr_ptr_dbg
);
  sched_state_e      state_q, state_d;
  logic [N_IN-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]  evt_idx_q, evt_idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              evt_valid, handshake, drop_any, arb_any;
  logic [N_IN-1:0]   accept_mask, capture, arb_req;
  logic [IDX_W-1:0]  idx_inc, arb_ptr, arb_winner;

  assign evt_valid   = (state_q == ST_OFFER);
  assign handshake   = evt_valid & evt.evt_ready;
  assign accept_mask = handshake ? (N_IN'(1) << evt_idx_q) : '0;
  assign capture     = boot_mode ? '0 : edge_spike;
  // A spike on the bit being accepted re-arms it rather than dropping.
  assign pending_d   = (pending_q & ~accept_mask) | capture;
  assign drop_any    = |(capture & pending_q & ~accept_mask);
  assign idx_inc     = (evt_idx_q == IDX_W'(N_IN - 1)) ? '0 : evt_idx_q + IDX_W'(1);

  // While offering, the next winner is chosen from post-accept pending so back-to-back offers have no bubble.
  assign arb_req = (state_q == ST_OFFER) ? pending_d : pending_q;
  assign arb_ptr = (state_q == ST_OFFER) ? idx_inc   : rr_ptr_q;

  rr_arbiter #(.N_IN(N_IN), .IDX_W(IDX_W)) u_rr_arbiter (
    .req    (arb_req),
    .ptr    (arb_ptr),
    .any    (arb_any),
    .winner (arb_winner)
  );

  always_comb begin
    state_d   = state_q;
    evt_idx_d = evt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (boot_mode) begin
          state_d = ST_HOLD;
        end else if (arb_any) begin
          state_d   = ST_OFFER;
          evt_idx_d = arb_winner;
        end
      end
      ST_OFFER: begin
        if (handshake) begin
          rr_ptr_d = idx_inc;
          if (!boot_mode && arb_any) begin
            evt_idx_d = arb_winner;
          end else begin
            state_d = boot_mode ? ST_HOLD : ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!boot_mode) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | drop_any;
    drop_cnt_d = drop_cnt_q;
    if (drop_any && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    if (drop_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      evt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      evt_idx_q  <= evt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign evt.evt_valid = evt_valid;
  assign evt.evt_idx   = evt_idx_q;
  assign pending       = pending_q;
  assign busy          = (|pending_q) | evt_valid;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
  assign state_dbg     = state_q;
  assign rr_ptr_dbg    = rr_ptr_q;
endmodule

// File: doc/spike_event_scheduler.md
SPIKE_EVENT_SCHEDULER -- requirements
Module: spike_event_scheduler

Interface
REQ-001 Parameter N_IN, default 8, number of input neuron lines.
REQ-002 Parameter IDX_W, default 3, event index width (clog2 of N_IN).
REQ-003 Parameter DROP_W, default 8, drop counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 boot_mode  input  1  high = weight load in progress: no capture, no new offers.
REQ-007 edge_spike  input  N_IN  one-cycle posedge pulses from the input edge detector.
REQ-008 evt_ready  input  1  downstream accumulator accepts the offered event.
REQ-009 drop_clr  input  1  synchronous clear of drop_cnt and overflow.
REQ-010 evt_valid  output  1  event offered.
REQ-011 evt_idx  output  IDX_W  index of the offered input neuron.
REQ-012 pending  output  N_IN  spikes captured and not yet delivered.
REQ-013 busy  output  1  high when pending is nonzero or evt_valid is high.
REQ-014 overflow  output  1  sticky: at least one spike was dropped.
REQ-015 drop_cnt  output  DROP_W  number of cycles with at least one drop, saturating.

Function
REQ-016 Capture: when boot_mode is low, pending_next = (pending & ~accept_mask) | edge_spike.
REQ-017 accept_mask is the one-hot of evt_idx in a handshake cycle (evt_valid & evt_ready), otherwise zero.
REQ-018 Drop: bit i drops when edge_spike[i] & pending[i] & ~accept_mask[i].
REQ-019 On any drop cycle: overflow set; drop_cnt +1, saturating at all-ones.
REQ-020 A spike on the bit being accepted in the same cycle re-arms that bit; it is not a drop.
REQ-021 When boot_mode is high, edge_spike is ignored and causes no drops; pending changes only by acceptance.
REQ-022 FSM states: IDLE, OFFER, HOLD.
REQ-023 IDLE: boot_mode high -> HOLD; else pending nonzero -> OFFER, registering the round-robin winner into evt_idx.
REQ-024 Round-robin: winner is the first set pending bit at or after rr_ptr, scanning upward modulo N_IN.
REQ-025 OFFER: evt_valid = 1; evt_idx and evt_valid stay stable until evt_ready.
REQ-026 On handshake, rr_ptr becomes (evt_idx+1) mod N_IN (N_IN-1 wraps to 0).
REQ-027 On handshake, OFFER continues only if boot_mode is low and pending_next is nonzero, with a new winner registered and no bubble.
REQ-028 On handshake, otherwise the next state is HOLD if boot_mode is high, else IDLE.
REQ-029 boot_mode rising during OFFER does not withdraw the offered event.
REQ-030 HOLD: evt_valid = 0; return to IDLE when boot_mode is low.
REQ-031 Latency: spike in cycle t -> pending bit set in cycle t+1 -> evt_valid in cycle t+2 (from IDLE).
REQ-032 drop_clr has priority over an increment in the same cycle; the result is zero/clear.
REQ-033 busy = |pending | evt_valid, combinational from registers.

Reset
REQ-034 Reset values: evt_valid 0, evt_idx 0, pending 0, overflow 0, drop_cnt 0, rr_ptr 0, state IDLE.
REQ-035 Reset mid-offer discards the offered event and all pending spikes without a handshake.
REQ-036 The first rising edge after reset release behaves as IDLE with empty pending.

Structure
REQ-037 Shared package snn_pkg holds the N_IN and IDX_W defaults and the scheduler state enum.
REQ-038 Round-robin selection is one sub-module, rr_arbiter: inputs req and ptr; outputs any and winner index; purely combinational.
REQ-039 All state is in spike_event_scheduler; there are no other sub-modules.

Verification
REQ-040 Single spike: edge_spike=8'h04 at t, evt_ready=1 -> evt_valid at t+2, evt_idx=2, pending=0 at t+3, busy low at t+3.
REQ-041 Burst with fairness: edge_spike=8'hFF for one cycle, evt_ready=1 -> indices 0..7 on 8 consecutive cycles with no bubble, rr_ptr ends at 0.
REQ-042 Backpressure and wrap: pending=8'h81, rr_ptr=7, evt_ready=0 for 3 cycles -> evt_idx=7 held stable; then ready -> 7, then 0.
REQ-043 Drop: bit 3 pending and not accepted, edge_spike=8'h08 twice more -> overflow=1, drop_cnt=2; drop_clr -> both 0.
REQ-044 Same-cycle re-arm: accept idx 5 while edge_spike=8'h20 -> no drop, idx 5 offered again.
REQ-045 Boot and reset: boot_mode high during OFFER -> current event completes, then HOLD, spikes ignored; rst low mid-offer -> all outputs at reset values immediately.
